clock_timebase_set: RTL

//   Time-base and time-set front end for the six-digit 7-segment clock. Sits directly

---
 rtl/clock_timebase_set.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/clock_timebase_set.sv
// clock_timebase_set
//   Time-base and time-set front end for the six-digit 7-segment clock.
//   Produces the 1 s tick, debounces the MODE and INC push-buttons, and
//   steps a RUN -> SET_MIN -> SET_HR -> RUN mode machine. INC presses become
//   one-cycle advance pulses for the minutes or hours chain, depending on mode.
//   Optional feature macro: TIMEBASE_BLINK_EN (adds the blink strobe used to
//   flash the field being set; without it blink is tied low).

module clock_timebase_set #(
   parameter int CLK_HZ      = 50_000_000,
   parameter int TICK_HZ     = 1,
   parameter int DEBOUNCE_MS = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_mode_n,
   input  logic       key_inc_n,
   output logic       sec_tick,
   output logic       min_inc,
   output logic       hr_inc,
   output logic [1:0] mode,
   output logic       blink
);

   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int DB_CYC   = (CLK_HZ / 1000) * DEBOUNCE_MS;

   // Widths hold the terminal count; the guard keeps them legal even when
   // the divider check below is about to reject the configuration.
   localparam int PRE_W = (TICK_DIV >= 2) ? $clog2(TICK_DIV) : 1;
   localparam int DB_W  = (DB_CYC >= 2) ? $clog2(DB_CYC) : 1;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYC - 1);

   localparam int KEY_MODE = 0;
   localparam int KEY_INC  = 1;

   typedef enum logic [1:0] {
      MODE_RUN     = 2'b00,
      MODE_SET_MIN = 2'b01,
      MODE_SET_HR  = 2'b10
   } mode_e;

   // Both dividers must be at least 2 or the counters cannot form a period.
   if (TICK_DIV < 2) begin : g_tick_div_check
      $error("clock_timebase_set: TICK_DIV must be >= 2");
   end
   if (DB_CYC < 2) begin : g_db_cyc_check
      $error("clock_timebase_set: DB_CYC must be >= 2");
   end

   // Key path state; index 0 is the MODE key, index 1 the INC key.
   logic [1:0]      sync1_q, sync1_d;
   logic [1:0]      sync2_q, sync2_d;
   logic [1:0]      stable_q, stable_d;
   logic [1:0]      press_q, press_d;
   logic [DB_W-1:0] db_cnt_q [2];
   logic [DB_W-1:0] db_cnt_d [2];

   // Mode machine, prescaler and registered output pulses.
   mode_e            mode_q, mode_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic             sec_tick_q, sec_tick_d;
   logic             min_inc_q, min_inc_d;
   logic             hr_inc_q, hr_inc_d;
   logic             run_steady;

   // Synchronise both keys and debounce them; a settled 1->0 is a press.
   always_comb begin
      sync1_d = {key_inc_n, key_mode_n};
      sync2_d = sync1_q;
      stable_d = stable_q;
      press_d  = 2'b00;
      for (int i = 0; i < 2; i++) begin
         db_cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               stable_d[i] = sync2_q[i];
               press_d[i]  = ~sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
         end
      end
   end

   // Key path registers; reset leaves both keys in the released state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q     <= 2'b11;
         sync2_q     <= 2'b11;
         stable_q    <= 2'b11;
         press_q     <= 2'b00;
         db_cnt_q[0] <= '0;
         db_cnt_q[1] <= '0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         stable_q    <= stable_d;
         press_q     <= press_d;
         db_cnt_q[0] <= db_cnt_d[0];
         db_cnt_q[1] <= db_cnt_d[1];
      end
   end

   // Next mode, increment pulses and the seconds prescaler.
   always_comb begin
      mode_d = mode_q;
      if (press_q[KEY_MODE]) begin
         case (mode_q)
            MODE_RUN:     mode_d = MODE_SET_MIN;
            MODE_SET_MIN: mode_d = MODE_SET_HR;
            default:      mode_d = MODE_RUN;
         endcase
      end

      // A MODE press in the same cycle swallows the INC press.
      min_inc_d = press_q[KEY_INC] && !press_q[KEY_MODE] && (mode_q == MODE_SET_MIN);
      hr_inc_d  = press_q[KEY_INC] && !press_q[KEY_MODE] && (mode_q == MODE_SET_HR);

      // The prescaler only runs in a RUN cycle that is not also leaving RUN,
      // so re-entering RUN always starts a full period from zero.
      run_steady = (mode_q == MODE_RUN) && !press_q[KEY_MODE];
      pre_d      = '0;
      sec_tick_d = 1'b0;
      if (run_steady) begin
         if (pre_q == PRE_LAST) begin
            sec_tick_d = 1'b1;
         end else begin
            pre_d = pre_q + PRE_W'(1);
         end
      end
   end

   // Mode machine and output registers; reset aborts anything in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q     <= MODE_RUN;
         pre_q      <= '0;
         sec_tick_q <= 1'b0;
         min_inc_q  <= 1'b0;
         hr_inc_q   <= 1'b0;
      end else begin
         mode_q     <= mode_d;
         pre_q      <= pre_d;
         sec_tick_q <= sec_tick_d;
         min_inc_q  <= min_inc_d;
         hr_inc_q   <= hr_inc_d;
      end
   end

`ifdef TIMEBASE_BLINK_EN
   localparam int BLINK_DIV = (TICK_DIV / 4 >= 1) ? TICK_DIV / 4 : 1;
   localparam int BLINK_W   = (BLINK_DIV >= 2) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               blink_q, blink_d;

   // Blink strobe runs only while a field is being set and restarts on
   // every mode change so each field begins visible.
   always_comb begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
      if ((mode_q != MODE_RUN) && !press_q[KEY_MODE]) begin
         blink_d = blink_q;
         if (blink_cnt_q == BLINK_LAST) begin
            blink_d = ~blink_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
         end
      end
   end

   // Blink strobe registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt_q <= '0;
         blink_q     <= 1'b0;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
      end
   end

   assign blink = blink_q;
`else
   assign blink = 1'b0;
`endif

   assign sec_tick = sec_tick_q;
   assign min_inc  = min_inc_q;
   assign hr_inc   = hr_inc_q;
   assign mode     = mode_q;

endmodule
